fir_ctrl: RTL and testbench
===========================

FIR_CTRL -- requirements
Module: fir_ctrl

Interface
REQ-001 SHALL have parameter pADDR_WIDTH, default 12, the AXI-lite and BRAM address width.
REQ-002 SHALL have parameter pDATA_WIDTH, default 32, the data and coefficient width.
REQ-003 SHALL have one clock and an asynchronous, active-low reset, named axis_clk and axis_rst_n.
REQ-004 axis_clk  in  1  clock, all logic on its rising edge.
REQ-005 axis_rst_n  in  1  asynchronous active-low reset.
REQ-006 awvalid/awaddr  in  1/pADDR_WIDTH, awready out 1: AXI-lite write address.
REQ-007 wvalid/wdata  in  1/pDATA_WIDTH, wready out 1: AXI-lite write data.
REQ-008 arvalid/araddr  in  1/pADDR_WIDTH, arready out 1: AXI-lite read address.
REQ-009 rready  in  1, rvalid/rdata out 1/pDATA_WIDTH: AXI-lite read data.
REQ-010 tap_WE/tap_EN/tap_Di/tap_A  out  4/1/pDATA_WIDTH/pADDR_WIDTH, tap_Do in pDATA_WIDTH: tap BRAM port, byte address.
REQ-011 eng_tap_A  in  pADDR_WIDTH: engine tap read address, byte address.
REQ-012 out_hs/out_last  in  1/1: engine output-stream handshake, and tlast qualified by it.
REQ-013 ap_start_pulse/running  out  1/1: one-cycle engine start; engine-active level.
REQ-014 data_length/tap_num  out  32/32: configuration registers.

Function
REQ-015 Register map SHALL be: 0x00 ap_ctrl; 0x10 data_length; 0x14 tap_num; 0x80-0xFF tap RAM window; any other read returns 0; any other write is ignored.
REQ-016 ap_ctrl SHALL be bit0 ap_start, bit1 ap_done, bit2 ap_idle; other bits read 0.
REQ-017 Write SHALL complete when awvalid and wvalid are both high: awready=wready=1 for exactly that cycle; there is no other write channel.
REQ-018 Read SHALL assert arready for one cycle on arvalid when no read is pending, then rvalid the next cycle, holding rdata/rvalid stable until rready.
REQ-019 A simultaneous read and write SHALL be served write-first; the read is accepted the following cycle.
REQ-020 FSM SHALL have states IDLE, RUN, DONE.
REQ-021 Writing 0x00 with bit0=1 in IDLE SHALL pulse ap_start_pulse for one cycle, clear ap_idle and ap_done, and enter RUN.
REQ-022 Writing ap_start outside IDLE SHALL be ignored.
REQ-023 In RUN, a 32-bit counter SHALL count out_hs.
REQ-024 The out_hs with out_last=1, or with count==data_length-1, SHALL set ap_done=1 and ap_idle=1 the next cycle and enter DONE.
REQ-025 With data_length=0, only out_last SHALL end RUN.
REQ-026 Reading 0x00 in DONE SHALL return ap_done=1, then clear ap_done and return to IDLE.
REQ-027 running SHALL be 1 only in RUN.
REQ-028 Tap window: tap_A SHALL be awaddr-0x80 or araddr-0x80, with tap_WE=4'hF on write and tap_EN=1.
REQ-029 In RUN, tap_A SHALL be eng_tap_A with tap_WE=0; AXI-lite tap writes SHALL complete but be discarded, and tap reads SHALL return 0xFFFFFFFF.
REQ-030 Writes to data_length/tap_num in RUN SHALL be ignored.

Reset
REQ-031 Reset SHALL take effect immediately, async assert and sync deassert, with outputs: ap_idle=1; ap_start=0; ap_done=0; all ready/valid=0; rdata=0; tap_EN=0; tap_WE=0; data_length=0; tap_num=0; counter=0; state IDLE.
REQ-032 Reset asserted mid-RUN SHALL abandon the run; pending AXI transactions are dropped.

Structure
REQ-033 A shared package fir_pkg SHALL hold register offsets (0x00, 0x10, 0x14, 0x80), ap_ctrl bit indices, and the FSM state enum.
REQ-034 One sub-module, fir_axil_slave, SHALL provide the AXI-lite handshakes; the FSM and tap mux reside in fir_ctrl.

Verification
REQ-035 Write 0x10=400, 0x14=32 -> each write takes one cycle with awready/wready; readback returns 400 and 32.
REQ-036 Write 32 taps at 0x80+4k=k-5 in IDLE, then read back -> each read returns k-5, with rvalid one cycle after arready.
REQ-037 Write 0x00=1 -> one-cycle ap_start_pulse; read 0x00 returns bit2=0 and bit0=0.
REQ-038 In RUN, write 0x84=7 then read 0x84 -> returns 0xFFFFFFFF; after done, read 0x84 returns the original value.
REQ-039 400 out_hs with out_last on the 400th -> the first 0x00 read returns 0x6, the next returns 0x4.
REQ-040 Assert axis_rst_n=0 after 100 outputs -> next cycle ap_idle=1, running=0, and data_length=0.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR control block: register map, ap_ctrl bit
// positions and the engine-control state encoding.
package fir_pkg;

  localparam int unsigned REG_AP_CTRL  = 32'h00;
  localparam int unsigned REG_DATA_LEN = 32'h10;
  localparam int unsigned REG_TAP_NUM  = 32'h14;
  localparam int unsigned REG_TAP_BASE = 32'h80;
  localparam int unsigned REG_TAP_LAST = 32'hFF;

  localparam int unsigned AP_START_BIT = 0;
  localparam int unsigned AP_DONE_BIT  = 1;
  localparam int unsigned AP_IDLE_BIT  = 2;

  localparam int unsigned CFG_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fir_state_e;

endpackage

// File: rtl/fir_axil_slave.sv
// AXI-lite handshake engine: single-cycle writes, one outstanding read, write
// wins a same-cycle collision. Read data is either latched at accept or taken
// from the BRAM output on the first rvalid cycle and then held.
module fir_axil_slave #(
  parameter int unsigned pDATA_WIDTH = 32
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic                   arvalid,
  output logic                   arready,
  input  logic                   rready,
  output logic                   rvalid,
  output logic [pDATA_WIDTH-1:0] rdata,
  output logic                   wr_fire_c,
  output logic                   rd_fire_c,
  input  logic                   rd_live_c,
  input  logic [pDATA_WIDTH-1:0] rd_imm_c,
  input  logic [pDATA_WIDTH-1:0] bram_data
);

  logic                   rvalid_q;
  logic                   rd_live_q;
  logic [pDATA_WIDTH-1:0] rdata_q;

  assign wr_fire_c = awvalid & wvalid;
  assign rd_fire_c = arvalid & ~rvalid_q & ~wr_fire_c;

  assign awready = wr_fire_c;
  assign wready  = wr_fire_c;
  assign arready = rd_fire_c;
  assign rvalid  = rvalid_q;

  // BRAM data is only valid the cycle after its address; capture it then hold.
  assign rdata = rd_live_q ? bram_data : rdata_q;

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      rvalid_q  <= 1'b0;
      rd_live_q <= 1'b0;
      rdata_q   <= '0;
    end else if (rd_fire_c) begin
      rvalid_q  <= 1'b1;
      rd_live_q <= rd_live_c;
      rdata_q   <= rd_imm_c;
    end else if (rvalid_q) begin
      rd_live_q <= 1'b0;
      rdata_q   <= rdata;
      if (rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fir_ctrl.sv
// FIR control block: configuration registers, ap_ctrl start/done FSM and the
// tap BRAM port mux shared between AXI-lite and the filter engine.
module fir_ctrl
  import fir_pkg::*;
#(
  parameter int unsigned pADDR_WIDTH = 12,
  parameter int unsigned pDATA_WIDTH = 32
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   awvalid,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  output logic                   awready,
  input  logic                   wvalid,
  input  logic [pDATA_WIDTH-1:0] wdata,
  output logic                   wready,
  input  logic                   arvalid,
  input  logic [pADDR_WIDTH-1:0] araddr,
  output logic                   arready,
  input  logic                   rready,
  output logic                   rvalid,
  output logic [pDATA_WIDTH-1:0] rdata,
  output logic [3:0]             tap_WE,
  output logic                   tap_EN,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  output logic [pADDR_WIDTH-1:0] tap_A,
  input  logic [pDATA_WIDTH-1:0] tap_Do,
  input  logic [pADDR_WIDTH-1:0] eng_tap_A,
  input  logic                   out_hs,
  input  logic                   out_last,
  output logic                   ap_start_pulse,
  output logic                   running,
  output logic [CFG_WIDTH-1:0]   data_length,
  output logic [CFG_WIDTH-1:0]   tap_num
);

  localparam logic [pADDR_WIDTH-1:0] A_AP_CTRL  = pADDR_WIDTH'(REG_AP_CTRL);
  localparam logic [pADDR_WIDTH-1:0] A_DATA_LEN = pADDR_WIDTH'(REG_DATA_LEN);
  localparam logic [pADDR_WIDTH-1:0] A_TAP_NUM  = pADDR_WIDTH'(REG_TAP_NUM);
  localparam logic [pADDR_WIDTH-1:0] A_TAP_BASE = pADDR_WIDTH'(REG_TAP_BASE);
  localparam logic [pADDR_WIDTH-1:0] A_TAP_LAST = pADDR_WIDTH'(REG_TAP_LAST);

  fir_state_e             state_q, state_d;
  logic                   start_q, start_d;
  logic                   done_q, done_d;
  logic                   idle_q, idle_d;
  logic                   running_q, running_d;
  logic [CFG_WIDTH-1:0]   cnt_q, cnt_d;
  logic [CFG_WIDTH-1:0]   dlen_q, dlen_d;
  logic [CFG_WIDTH-1:0]   tnum_q, tnum_d;

  logic                   wr_fire_c, rd_fire_c, rd_live_c;
  logic                   aw_tap_c, ar_tap_c, last_out_c;
  logic [pDATA_WIDTH-1:0] rd_imm_c, ap_ctrl_c;

  fir_axil_slave #(
    .pDATA_WIDTH(pDATA_WIDTH)
  ) u_axil (
    .axis_clk   (axis_clk),
    .axis_rst_n (axis_rst_n),
    .awvalid    (awvalid),
    .awready    (awready),
    .wvalid     (wvalid),
    .wready     (wready),
    .arvalid    (arvalid),
    .arready    (arready),
    .rready     (rready),
    .rvalid     (rvalid),
    .rdata      (rdata),
    .wr_fire_c  (wr_fire_c),
    .rd_fire_c  (rd_fire_c),
    .rd_live_c  (rd_live_c),
    .rd_imm_c   (rd_imm_c),
    .bram_data  (tap_Do)
  );

  assign aw_tap_c = (awaddr >= A_TAP_BASE) && (awaddr <= A_TAP_LAST);
  assign ar_tap_c = (araddr >= A_TAP_BASE) && (araddr <= A_TAP_LAST);

  // data_length of zero disables the count terminal; only tlast ends the run.
  assign last_out_c = out_last || ((dlen_q != '0) && (cnt_q == dlen_q - CFG_WIDTH'(1)));

  assign ap_start_pulse = start_q;
  assign running        = running_q;
  assign data_length    = dlen_q;
  assign tap_num        = tnum_q;

  always_comb begin
    ap_ctrl_c               = '0;
    ap_ctrl_c[AP_START_BIT] = start_q;
    ap_ctrl_c[AP_DONE_BIT]  = done_q;
    ap_ctrl_c[AP_IDLE_BIT]  = idle_q;
  end

  // Read source select at accept time.
  always_comb begin
    rd_imm_c  = '0;
    rd_live_c = 1'b0;
    if (araddr == A_AP_CTRL) begin
      rd_imm_c = ap_ctrl_c;
    end else if (araddr == A_DATA_LEN) begin
      rd_imm_c = pDATA_WIDTH'(dlen_q);
    end else if (araddr == A_TAP_NUM) begin
      rd_imm_c = pDATA_WIDTH'(tnum_q);
    end else if (ar_tap_c) begin
      if (state_q == ST_RUN) begin
        rd_imm_c = '1;
      end else begin
        rd_live_c = 1'b1;
      end
    end
  end

  // Tap BRAM port: engine owns it while running, otherwise AXI-lite (write first).
  always_comb begin
    tap_EN = 1'b0;
    tap_WE = 4'h0;
    tap_A  = '0;
    tap_Di = wdata;
    if (state_q == ST_RUN) begin
      tap_EN = 1'b1;
      tap_A  = eng_tap_A;
    end else if (wr_fire_c && aw_tap_c) begin
      tap_EN = 1'b1;
      tap_WE = 4'hF;
      tap_A  = awaddr - A_TAP_BASE;
    end else if (rd_fire_c && ar_tap_c) begin
      tap_EN = 1'b1;
      tap_A  = araddr - A_TAP_BASE;
    end
  end

  always_comb begin
    state_d   = state_q;
    start_d   = 1'b0;
    done_d    = done_q;
    idle_d    = idle_q;
    running_d = running_q;
    cnt_d     = cnt_q;
    dlen_d    = dlen_q;
    tnum_d    = tnum_q;

    case (state_q)
      ST_IDLE: begin
        if (wr_fire_c && (awaddr == A_AP_CTRL) && wdata[AP_START_BIT]) begin
          state_d   = ST_RUN;
          start_d   = 1'b1;
          done_d    = 1'b0;
          idle_d    = 1'b0;
          running_d = 1'b1;
          cnt_d     = '0;
        end
      end
      ST_RUN: begin
        if (out_hs) begin
          cnt_d = cnt_q + CFG_WIDTH'(1);
          if (last_out_c) begin
            state_d   = ST_DONE;
            done_d    = 1'b1;
            idle_d    = 1'b1;
            running_d = 1'b0;
          end
        end
      end
      ST_DONE: begin
        // Host sees done once through the ap_ctrl read, which retires it.
        if (rd_fire_c && (araddr == A_AP_CTRL)) begin
          state_d = ST_IDLE;
          done_d  = 1'b0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        done_d    = 1'b0;
        idle_d    = 1'b1;
        running_d = 1'b0;
      end
    endcase

    if (wr_fire_c && (state_q != ST_RUN)) begin
      if (awaddr == A_DATA_LEN) dlen_d = CFG_WIDTH'(wdata);
      if (awaddr == A_TAP_NUM)  tnum_d = CFG_WIDTH'(wdata);
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_q   <= ST_IDLE;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
      idle_q    <= 1'b1;
      running_q <= 1'b0;
      cnt_q     <= '0;
      dlen_q    <= '0;
      tnum_q    <= '0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      done_q    <= done_d;
      idle_q    <= idle_d;
      running_q <= running_d;
      cnt_q     <= cnt_d;
      dlen_q    <= dlen_d;
      tnum_q    <= tnum_d;
    end
  end

endmodule

// File: tb/tb_fir_ctrl.sv
// Directed bench for fir_ctrl with a behavioural tap BRAM (registered read).
module tb_fir_ctrl;

  logic        axis_clk = 1'b0;
  logic        axis_rst_n;
  logic        awvalid, wvalid, arvalid, rready;
  logic [11:0] awaddr, araddr, eng_tap_A;
  logic [31:0] wdata;
  logic        awready, wready, arready, rvalid;
  logic [31:0] rdata;
  logic [3:0]  tap_WE;
  logic        tap_EN;
  logic [31:0] tap_Di, tap_Do;
  logic [11:0] tap_A;
  logic        out_hs, out_last;
  logic        ap_start_pulse, running;
  logic [31:0] data_length, tap_num;

  int errors = 0;
  int checks = 0;

  logic [31:0] bram [0:31];

  always #5 axis_clk = ~axis_clk;

  always @(posedge axis_clk) begin
    if (tap_EN) begin
      if (tap_WE == 4'hF) bram[tap_A[6:2]] <= tap_Di;
      tap_Do <= bram[tap_A[6:2]];
    end
  end

  fir_ctrl #(.pADDR_WIDTH(12), .pDATA_WIDTH(32)) dut (
    .axis_clk       (axis_clk),
    .axis_rst_n     (axis_rst_n),
    .awvalid        (awvalid),
    .awaddr         (awaddr),
    .awready        (awready),
    .wvalid         (wvalid),
    .wdata          (wdata),
    .wready         (wready),
    .arvalid        (arvalid),
    .araddr         (araddr),
    .arready        (arready),
    .rready         (rready),
    .rvalid         (rvalid),
    .rdata          (rdata),
    .tap_WE         (tap_WE),
    .tap_EN         (tap_EN),
    .tap_Di         (tap_Di),
    .tap_A          (tap_A),
    .tap_Do         (tap_Do),
    .eng_tap_A      (eng_tap_A),
    .out_hs         (out_hs),
    .out_last       (out_last),
    .ap_start_pulse (ap_start_pulse),
    .running        (running),
    .data_length    (data_length),
    .tap_num        (tap_num)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] exp_we);
    @(negedge axis_clk);
    awvalid = 1'b1; wvalid = 1'b1; awaddr = addr; wdata = data;
    #1;
    chk("awready", 32'(awready), 32'd1);
    chk("wready", 32'(wready), 32'd1);
    chk("tap_WE", 32'(tap_WE), 32'(exp_we));
    @(negedge axis_clk);
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic axi_read(input string tag, input logic [11:0] addr, input logic [31:0] exp, input int hold);
    @(negedge axis_clk);
    arvalid = 1'b1; araddr = addr;
    #1;
    chk({tag, "_arready"}, 32'(arready), 32'd1);
    @(negedge axis_clk);
    arvalid = 1'b0;
    chk({tag, "_rvalid"}, 32'(rvalid), 32'd1);
    chk(tag, rdata, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge axis_clk);
      chk({tag, "_hold"}, rdata, exp);
      chk({tag, "_rvalid_hold"}, 32'(rvalid), 32'd1);
    end
    rready = 1'b1;
    @(negedge axis_clk);
    rready = 1'b0;
    chk({tag, "_rvalid_clr"}, 32'(rvalid), 32'd0);
  endtask

  task automatic pulse_outputs(input int n, input logic last_on_final);
    for (int i = 0; i < n; i++) begin
      @(negedge axis_clk);
      out_hs = 1'b1;
      out_last = last_on_final && (i == n - 1);
    end
    @(negedge axis_clk);
    out_hs = 1'b0; out_last = 1'b0;
  endtask

  task automatic start_run();
    axi_write(12'h000, 32'h1, 4'h0);
    chk("start_pulse", 32'(ap_start_pulse), 32'd1);
    chk("running_start", 32'(running), 32'd1);
    @(negedge axis_clk);
    chk("start_pulse_once", 32'(ap_start_pulse), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    axis_rst_n = 1'b0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; rready = 1'b0;
    awaddr = '0; araddr = '0; wdata = '0; eng_tap_A = 12'h010;
    out_hs = 1'b0; out_last = 1'b0;

    repeat (3) @(negedge axis_clk);
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_tap_EN", 32'(tap_EN), 32'd0);
    chk("rst_tap_WE", 32'(tap_WE), 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_start", 32'(ap_start_pulse), 32'd0);
    chk("rst_dlen", data_length, 32'd0);
    chk("rst_tnum", tap_num, 32'd0);
    axis_rst_n = 1'b1;

    axi_read("ctrl_idle", 12'h000, 32'h4, 0);

    axi_write(12'h010, 32'd400, 4'h0);
    axi_write(12'h014, 32'd32, 4'h0);
    axi_read("rd_dlen", 12'h010, 32'd400, 2);
    axi_read("rd_tnum", 12'h014, 32'd32, 0);
    chk("port_dlen", data_length, 32'd400);
    chk("port_tnum", tap_num, 32'd32);

    // Collision: write served first, read accepted the cycle after.
    @(negedge axis_clk);
    awvalid = 1'b1; wvalid = 1'b1; awaddr = 12'h014; wdata = 32'd33;
    arvalid = 1'b1; araddr = 12'h010;
    #1;
    chk("coll_awready", 32'(awready), 32'd1);
    chk("coll_arready_blocked", 32'(arready), 32'd0);
    @(negedge axis_clk);
    awvalid = 1'b0; wvalid = 1'b0;
    #1;
    chk("coll_arready", 32'(arready), 32'd1);
    @(negedge axis_clk);
    arvalid = 1'b0;
    chk("coll_rvalid", 32'(rvalid), 32'd1);
    chk("coll_rdata", rdata, 32'd400);
    rready = 1'b1;
    @(negedge axis_clk);
    rready = 1'b0;
    chk("coll_tnum", tap_num, 32'd33);

    axi_write(12'h020, 32'hDEAD, 4'h0);
    axi_read("rd_unmapped20", 12'h020, 32'd0, 0);
    axi_read("rd_unmapped04", 12'h004, 32'd0, 0);

    for (int k = 0; k < 32; k++) begin
      v = 32'(k - 5);
      axi_write(12'h080 + 12'(4 * k), v, 4'hF);
    end
    for (int k = 0; k < 32; k++) begin
      v = 32'(k - 5);
      axi_read("rd_tap", 12'h080 + 12'(4 * k), v, (k == 3) ? 2 : 0);
    end

    // Run 1: 400 outputs, tlast on the last one.
    start_run();
    chk("run_tap_A", 32'(tap_A), 32'h010);
    chk("run_tap_EN", 32'(tap_EN), 32'd1);
    axi_read("ctrl_run", 12'h000, 32'h0, 0);
    axi_write(12'h084, 32'd7, 4'h0);
    axi_read("rd_tap_run", 12'h084, 32'hFFFF_FFFF, 0);
    axi_write(12'h010, 32'd5, 4'h0);
    chk("dlen_locked", data_length, 32'd400);
    axi_write(12'h000, 32'h1, 4'h0);
    chk("restart_ignored", 32'(ap_start_pulse), 32'd0);
    pulse_outputs(399, 1'b0);
    chk("run1_still_running", 32'(running), 32'd1);
    pulse_outputs(1, 1'b1);
    chk("run1_done", 32'(running), 32'd0);
    axi_read("ctrl_done1", 12'h000, 32'h6, 0);
    axi_read("ctrl_idle1", 12'h000, 32'h4, 0);
    axi_read("rd_tap_after", 12'h084, 32'hFFFF_FFFC, 0);

    // Run 2: count terminal without tlast.
    axi_write(12'h010, 32'd3, 4'h0);
    start_run();
    pulse_outputs(2, 1'b0);
    chk("run2_still_running", 32'(running), 32'd1);
    pulse_outputs(1, 1'b0);
    chk("run2_done", 32'(running), 32'd0);
    axi_read("ctrl_done2", 12'h000, 32'h6, 0);
    axi_read("ctrl_idle2", 12'h000, 32'h4, 0);

    // Run 3: data_length=0 ends only on tlast.
    axi_write(12'h010, 32'd0, 4'h0);
    start_run();
    pulse_outputs(5, 1'b0);
    chk("run3_still_running", 32'(running), 32'd1);
    pulse_outputs(1, 1'b1);
    chk("run3_done", 32'(running), 32'd0);
    axi_read("ctrl_done3", 12'h000, 32'h6, 0);
    axi_read("ctrl_idle3", 12'h000, 32'h4, 0);

    // Run 4: reset mid-run.
    axi_write(12'h010, 32'd400, 4'h0);
    start_run();
    pulse_outputs(100, 1'b0);
    chk("run4_running", 32'(running), 32'd1);
    axis_rst_n = 1'b0;
    #1;
    chk("rst_mid_running", 32'(running), 32'd0);
    chk("rst_mid_dlen", data_length, 32'd0);
    chk("rst_mid_tnum", tap_num, 32'd0);
    chk("rst_mid_tap_EN", 32'(tap_EN), 32'd0);
    @(negedge axis_clk);
    axis_rst_n = 1'b1;
    axi_read("ctrl_after_rst", 12'h000, 32'h4, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
